// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        BUSY_KILL = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Two-entry {inst, pc} FIFO; slot 0 is always the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [31:0]       push_inst_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic              head_valid_o,
    output logic [31:0]       head_inst_o,
    output logic [ADDR_W-1:0] head_pc_o
);

    logic [31:0]       inst0_q, inst0_d;
    logic [31:0]       inst1_q, inst1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d;
    logic [ADDR_W-1:0] pc1_q, pc1_d;
    logic [1:0]        occ_q, occ_d;
    logic              pop_w;
    logic [1:0]        occ_after_pop_w;

    assign pop_w           = pop_i && (occ_q != 2'd0);
    assign occ_after_pop_w = occ_q - {1'b0, pop_w};

    always_comb begin
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        occ_d   = occ_q;
        if (flush_i) begin
            inst0_d = NOP_INST;
            pc0_d   = '0;
            occ_d   = 2'd0;
        end else begin
            // An emptied head reverts to NOP so the decoded fields stay benign.
            if (pop_w) begin
                if (occ_q == 2'd2) begin
                    inst0_d = inst1_q;
                    pc0_d   = pc1_q;
                end else begin
                    inst0_d = NOP_INST;
                    pc0_d   = '0;
                end
            end
            if (push_i) begin
                if (occ_after_pop_w == 2'd0) begin
                    inst0_d = push_inst_i;
                    pc0_d   = push_pc_i;
                end else begin
                    inst1_d = push_inst_i;
                    pc1_d   = push_pc_i;
                end
            end
            occ_d = occ_after_pop_w + {1'b0, push_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst0_q <= NOP_INST;
            inst1_q <= NOP_INST;
            pc0_q   <= '0;
            pc1_q   <= '0;
            occ_q   <= 2'd0;
        end else begin
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            occ_q   <= occ_d;
        end
    end

    assign occ_o        = occ_q;
    assign head_valid_o = (occ_q != 2'd0);
    assign head_inst_o  = inst0_q;
    assign head_pc_o    = pc0_q;

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push_i && !flush_i && !pop_w && (occ_q == 2'd2)));
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Single-outstanding instruction fetch with 2-entry buffer,
//               stall and redirect/flush. FETCH_STATS_EN enables counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [11:0]       csr,
    output logic [4:0]        rd,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_stall
);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;

    logic [1:0]        occ_w;
    logic [1:0]        occ_proj_w;
    logic              pop_w;
    logic              push_w;
    logic [ADDR_W-1:0] pc_inc_w;

    assign pop_w      = inst_valid && !stall;
    assign occ_proj_w = occ_w - {1'b0, pop_w};
    assign push_w     = (state_q == BUSY) && imem_ack && !redirect_valid;
    assign pc_inc_w   = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (occ_proj_w <= 2'd1) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                BUSY: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        if (imem_ack) begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= BUSY_KILL;
                        end
                    end else if (imem_ack) begin
                        pc_q <= pc_inc_w;
                        // Chain the next request only if the push still leaves a free slot.
                        if (occ_proj_w == 2'd0) begin
                            addr_q <= pc_inc_w;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                BUSY_KILL: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    if (imem_ack) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    fetch_queue #(
        .ADDR_W (ADDR_W)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push_w),
        .push_inst_i  (imem_rdata),
        .push_pc_i    (addr_q),
        .pop_i        (pop_w),
        .flush_i      (redirect_valid),
        .occ_o        (occ_w),
        .head_valid_o (inst_valid),
        .head_inst_o  (inst),
        .head_pc_o    (inst_pc)
    );

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign csr    = inst[31:20];

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (push_w) begin
                stat_fetched_q <= stat_fetched_q + 32'd1;
            end
            if (inst_valid && stall) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_stall   = stat_stall_q;
`else
    assign stat_fetched = '0;
    assign stat_stall   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage (vector table, directed
//               corner sequences, randomized run against a queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [11:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] stat_fetched, stat_stall;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7         (funct7),
        .csr            (csr),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .stat_fetched   (stat_fetched),
        .stat_stall     (stat_stall)
    );

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] csr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t tbl [6];

    int total = 0;
    int bad   = 0;

    // Reference model: buffered pcs, next fetch address, kill flag, counters.
    logic [11:0] mq[$];
    logic [11:0] dq[$];
    logic [11:0] fetch_pc;
    bit          kill;
    int          n_push, n_stall, cyc;
    bit          prev_req, prev_ack;
    logic [11:0] prev_addr;
    int          mem_cnt, mem_lat;
    bit          mem_rand, stray_en, force_stray, use_tbl;

    function automatic logic [31:0] memword(input logic [11:0] a);
        if (use_tbl && a < 12'd6) return tbl[int'(a)].word;
        return ({20'h0, a} * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        dq.delete();
        fetch_pc = 12'h000;
        kill = 0;
        n_push = 0;
        n_stall = 0;
        cyc = 0;
        prev_req = 0;
        prev_ack = 0;
        prev_addr = '0;
        mem_cnt = 0;
    endtask

    task automatic apply_reset(input bit chk);
        #2 reset = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        #1;
        if (chk) begin
            check("async_rst_req",   32'(imem_req), 0);
            check("async_rst_valid", 32'(inst_valid), 0);
            check("async_rst_inst",  inst, NOP);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: compare outputs to model, drive memory, advance model.
    task automatic cycle();
        logic [31:0] exp_w;
        bit mpop;
        exp_w = (mq.size() != 0) ? memword(mq[0]) : NOP;
        check("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
        check("inst", inst, exp_w);
        check("inst_pc", 32'(inst_pc), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check("fields", {funct7, rs2, rs1, funct3, rd, opcode}, exp_w);
        check("csr", 32'(csr), 32'(exp_w >> 20));
        if (imem_req && !kill) begin
            check("imem_addr", 32'(imem_addr), 32'(fetch_pc));
            check("req_room", 32'(mq.size() <= 1), 1);
        end
        if (imem_req && prev_req && !prev_ack) check("addr_stable", 32'(imem_addr), 32'(prev_addr));
        if (kill) check("kill_req_held", 32'(imem_req), 1);

        if (imem_req) begin
            if (mem_cnt >= mem_lat) begin
                imem_ack = 1'b1;
                imem_rdata = memword(imem_addr);
                mem_cnt = 0;
                if (mem_rand) mem_lat = $urandom_range(1, 3);
            end else begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
            imem_ack = force_stray || (stray_en && ($urandom_range(0, 9) == 0));
            imem_rdata = $urandom;
        end

        mpop = (mq.size() != 0) && !stall;
        if ((mq.size() != 0) && stall) n_stall++;
        if (redirect_valid) begin
            mq.delete();
            fetch_pc = redirect_pc;
            if (imem_req) kill = !imem_ack;
        end else begin
            if (mpop) dq.push_back(mq.pop_front());
            if (imem_req && imem_ack) begin
                if (kill) kill = 0;
                else begin
                    mq.push_back(fetch_pc);
                    fetch_pc = fetch_pc + 12'd1;
                    n_push++;
                end
            end
        end
        prev_req = imem_req;
        prev_ack = imem_ack;
        prev_addr = imem_addr;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_deliv(input int n, input int budget, input string name);
        int b = 0;
        while (dq.size() < n && b < budget) begin
            cycle();
            b++;
        end
        check(name, 32'(dq.size() >= n), 1);
    endtask

    task automatic check_stats(input string name);
`ifdef FETCH_STATS_EN
        check({name, "_fetched"}, stat_fetched, 32'(n_push));
        check({name, "_stall"},   stat_stall,   32'(n_stall));
`else
        check({name, "_fetched"}, stat_fetched, 32'd0);
        check({name, "_stall"},   stat_stall,   32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int gap, max_gap, nd;

        tbl[0] = '{32'h0050_0093, 7'b0010011, 3'd0, 7'd0,    12'h005, 5'd1,  5'd0, 5'd5};
        tbl[1] = '{32'h0020_81B3, 7'b0110011, 3'd0, 7'd0,    12'h002, 5'd3,  5'd1, 5'd2};
        tbl[2] = '{32'h4031_5233, 7'b0110011, 3'd5, 7'h20,   12'h403, 5'd4,  5'd2, 5'd3};
        tbl[3] = '{32'h1234_52B7, 7'b0110111, 3'd5, 7'd9,    12'h123, 5'd5,  5'd8, 5'd3};
        tbl[4] = '{32'h3000_2573, 7'b1110011, 3'd2, 7'd24,   12'h300, 5'd10, 5'd0, 5'd0};
        tbl[5] = '{32'hFFF0_0013, 7'b0010011, 3'd0, 7'h7F,   12'hFFF, 5'd0,  5'd0, 5'd31};

        mem_lat = 1; mem_rand = 0; stray_en = 0; force_stray = 0; use_tbl = 1;

        // Reset state and first-fetch latency, then the vector table.
        apply_reset(0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_inst", inst, NOP);
        check("rst_inst_pc", 32'(inst_pc), 0);
        check("rst_opcode", 32'(opcode), 32'h13);
        cycle();
        check("lat_req_c1", 32'(imem_req), 1);
        check("lat_addr_c1", 32'(imem_addr), 0);
        cycle();
        check("lat_valid_c2", 32'(inst_valid), 0);
        cycle();
        check("lat_valid_c3", 32'(inst_valid), 1);
        for (int i = 0; i < 6; i++) begin
            b = 0;
            while (!(inst_valid && inst_pc == 12'(i)) && b < 20) begin
                cycle();
                b++;
            end
            check("tbl_seen", 32'(inst_valid && inst_pc == 12'(i)), 1);
            check("tbl_opcode", 32'(opcode), 32'(tbl[i].op));
            check("tbl_funct3", 32'(funct3), 32'(tbl[i].f3));
            check("tbl_funct7", 32'(funct7), 32'(tbl[i].f7));
            check("tbl_csr",    32'(csr),    32'(tbl[i].csr));
            check("tbl_rd",     32'(rd),     32'(tbl[i].rd));
            check("tbl_rs1",    32'(rs1),    32'(tbl[i].rs1));
            check("tbl_rs2",    32'(rs2),    32'(tbl[i].rs2));
            cycle();
        end
        use_tbl = 0;

        // Long stall: exactly two words buffered, request parked, order kept.
        apply_reset(0);
        stall = 1'b1;
        repeat (12) cycle();
        check("stall_req_off", 32'(imem_req), 0);
        check("stall_valid", 32'(inst_valid), 1);
        check("stall_pushes", 32'(n_push), 2);
        check("stall_head_pc", 32'(inst_pc), 0);
        check_stats("stats_stall");
        stall = 1'b0;
        run_until_deliv(3, 20, "stall_release_timeout");
        if (dq.size() >= 3) begin
            check("stall_order0", 32'(dq[0]), 0);
            check("stall_order1", 32'(dq[1]), 1);
            check("stall_order2", 32'(dq[2]), 2);
        end

        // Redirect while BUSY; the stale ack arrives three cycles later.
        apply_reset(0);
        mem_lat = 3;
        cycle();
        redirect_valid = 1'b1; redirect_pc = 12'h100;
        cycle();
        redirect_valid = 1'b0;
        b = 0;
        while (!(imem_req && imem_addr == 12'h100) && b < 12) begin
            check("kill_no_valid", 32'(inst_valid), 0);
            cycle();
            b++;
        end
        check("kill_new_req", 32'(imem_req && imem_addr == 12'h100), 1);
        check("kill_no_push", 32'(n_push), 0);
        run_until_deliv(1, 20, "kill_deliv_timeout");
        if (dq.size() >= 1) check("kill_first_pc", 32'(dq[0]), 32'h100);

        // Redirect in the same cycle as the ack.
        apply_reset(0);
        mem_lat = 1;
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 12'h200;
        cycle();
        redirect_valid = 1'b0;
        run_until_deliv(2, 20, "same_cycle_timeout");
        if (dq.size() >= 2) begin
            check("same_cycle_pc0", 32'(dq[0]), 32'h200);
            check("same_cycle_pc1", 32'(dq[1]), 32'h201);
        end

        // PC wrap at the top of the address space.
        apply_reset(0);
        redirect_valid = 1'b1; redirect_pc = 12'hFFF;
        cycle();
        redirect_valid = 1'b0;
        run_until_deliv(2, 20, "wrap_timeout");
        if (dq.size() >= 2) begin
            check("wrap_pc0", 32'(dq[0]), 32'hFFF);
            check("wrap_pc1", 32'(dq[1]), 32'h000);
        end

        // Asynchronous reset with a request outstanding, then a stray ack.
        apply_reset(0);
        stall = 1'b1;
        b = 0;
        while (!(imem_req && inst_valid) && b < 10) begin
            cycle();
            b++;
        end
        check("midreq_setup", 32'(imem_req && inst_valid), 1);
        apply_reset(1);
        force_stray = 1;
        cycle();
        force_stray = 0;
        check("stray_ignored", 32'(inst_valid), 0);
        run_until_deliv(1, 20, "post_reset_timeout");
        if (dq.size() >= 1) check("post_reset_pc", 32'(dq[0]), 0);
        check_stats("stats_directed");

        // Randomized traffic against the queue model.
        apply_reset(0);
        mem_rand = 1; stray_en = 1; mem_lat = 2;
        gap = 0; max_gap = 0;
        for (int t = 0; t < 3000; t++) begin
            stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
            nd = dq.size();
            cycle();
            if (dq.size() != nd) gap = 0;
            else gap++;
            if (gap > max_gap) max_gap = gap;
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("random_progress", 32'(max_gap <= 200), 1);
        check("random_delivered", 32'(dq.size() > 300), 1);
        check_stats("stats_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
